// File: rtl/xy_waypoint_seq.sv
// xy_waypoint_seq: queues BCD XY waypoints and steps an XY controller
// through them, dwelling at each one, with move timeout and abort.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wp_in[7:0], wp_push waypoint ([7:4] X, [3:0] Y) and its write strobe
//   start               level, allows sequencing (sampled in IDLE and
//                       at the end of each dwell)
//   abort               pulse, back to IDLE, queue and target kept
//   x_pos, y_pos        current position reported by the XY controller
//   target_out[7:0]     target presented to the XY controller
//   motion              motion request (high only while moving)
//   wp_full, wp_count   registered FIFO status
//   busy                high in every state but IDLE
//   done                pulse when the last queued waypoint finishes dwell
//   err                 pulse on move timeout or rejected push
//
// Option macro XYSEQ_BCD_CHECK_EN: when defined, pushes with a nibble
// above 9 are rejected (not stored) and flagged on err.

module xy_waypoint_seq #(
  parameter int DEPTH   = 4,
  parameter int DWELL   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wp_in,
  input  logic       wp_push,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] x_pos,
  input  logic [3:0] y_pos,
  output logic [7:0] target_out,
  output logic       motion,
  output logic       wp_full,
  output logic [4:0] wp_count,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_DWELL
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [4:0]    cnt_q, cnt_d;
  logic          full_q, full_d;
  logic [7:0]    tgt_q;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic wp_ok;
  logic pop;
  logic push_acc;
  logic push_rej;
  logic arrive;
  logic t_last;
  logic d_last;
  logic has_wp;
  logic tout;

`ifdef XYSEQ_BCD_CHECK_EN
  assign wp_ok = (wp_in[7:4] <= 4'd9)
              && (wp_in[3:0] <= 4'd9);
`else
  assign wp_ok = 1'b1;
`endif

  // LOAD always sees a non-empty FIFO; abort in LOAD keeps the head.
  assign pop      = (state_q == S_LOAD) && !abort;
  // A simultaneous pop frees a slot, so a full FIFO still accepts.
  assign push_acc = wp_push && wp_ok
                 && (!full_q || pop);
  assign push_rej = wp_push && !push_acc;

  assign arrive = ({x_pos, y_pos} == tgt_q);
  assign t_last = (tcnt_q == 16'(TIMEOUT - 1));
  assign d_last = (tcnt_q == 16'(DWELL - 1));
  assign has_wp = (cnt_q != 5'd0);
  assign tout   = (state_q == S_MOVE) && !arrive
               && t_last && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && has_wp) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_MOVE;
      end
      S_MOVE: begin
        if (arrive)      state_d = S_DWELL;
        else if (t_last) state_d = S_IDLE;
      end
      S_DWELL: begin
        if (d_last) begin
          if (start && has_wp) state_d = S_LOAD;
          else                 state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    motion = (state_q == S_MOVE);
  end

  // One counter serves both the move timeout and the dwell time;
  // it restarts from 0 on every state change.
  always_comb begin
    tcnt_d = 16'd0;
    if ((state_d == state_q)
        && ((state_q == S_MOVE)
         || (state_q == S_DWELL)))
      tcnt_d = tcnt_q + 16'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == 5'(DEPTH));
  end

  always_comb begin
    done_d = (state_q == S_DWELL) && d_last
          && !abort && !has_wp;
    err_d  = tout || push_rej;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= 5'd0;
      full_q <= 1'b0;
      tgt_q  <= 8'h00;
      tcnt_q <= 16'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push_acc) wr_q <= AW'(wr_q + 1'b1);
      if (pop) begin
        rd_q  <= AW'(rd_q + 1'b1);
        tgt_q <= mem_q[rd_q];
      end
      cnt_q  <= cnt_d;
      full_q <= full_d;
      tcnt_q <= tcnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem_q[wr_q] <= wp_in;
  end

  assign target_out = tgt_q;
  assign wp_full    = full_q;
  assign wp_count   = cnt_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_xy_waypoint_seq.sv
// tb_xy_waypoint_seq: directed self-checking bench for xy_waypoint_seq
// (DEPTH=4, DWELL=8, TIMEOUT=20) with a simple position follower.

module tb_xy_waypoint_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wp_in;
  logic       wp_push;
  logic       start;
  logic       abort;
  logic [3:0] x_pos;
  logic [3:0] y_pos;
  logic [7:0] target_out;
  logic       motion;
  logic       wp_full;
  logic [4:0] wp_count;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  bit follow = 0;

  logic [7:0] tgt_log [8];
  int low_log [8];
  int n_mv, n_done, n_err, n_hi;

  xy_waypoint_seq #(
    .DEPTH  (4),
    .DWELL  (8),
    .TIMEOUT(20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wp_in     (wp_in),
    .wp_push   (wp_push),
    .start     (start),
    .abort     (abort),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .target_out(target_out),
    .motion    (motion),
    .wp_full   (wp_full),
    .wp_count  (wp_count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the edge and let the
  // follower step one unit per axis toward the target.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (follow && motion) begin
      if (x_pos < target_out[7:4])      x_pos++;
      else if (x_pos > target_out[7:4]) x_pos--;
      if (y_pos < target_out[3:0])      y_pos++;
      else if (y_pos > target_out[3:0]) y_pos--;
    end
  endtask

  task automatic push(input logic [7:0] v);
    wp_in   = v;
    wp_push = 1'b1;
    cyc();
    wp_push = 1'b0;
  endtask

  task automatic run_seq(input int maxc);
    logic pm;
    bit   fin;
    n_mv = 0;
    n_done = 0;
    n_err = 0;
    n_hi = 0;
    for (int k = 0; k < 8; k++) begin
      low_log[k] = 0;
      tgt_log[k] = 8'h00;
    end
    pm  = motion;
    fin = 0;
    for (int i = 0; i < maxc && !fin; i++) begin
      cyc();
      if (motion && !pm && n_mv < 8) begin
        tgt_log[n_mv] = target_out;
        n_mv++;
      end
      if (busy && !motion && n_mv > 0)
        low_log[n_mv-1]++;
      if (motion) n_hi++;
      if (err)    n_err++;
      if (done)   n_done++;
      if (!busy && n_mv > 0) fin = 1;
      pm = motion;
    end
    if (!fin) chk("seq_bound", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    wp_in   = 8'h00;
    wp_push = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    x_pos   = 4'h0;
    y_pos   = 4'h0;
    cyc();
    cyc();
    chk("rst_tgt",   target_out, 8'h00);
    chk("rst_mot",   motion, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_cnt",   wp_count, 0);
    chk("rst_full",  wp_full, 0);
    reset = 1'b0;
    cyc();

    // Two waypoints, follower drives position to each target.
    push(8'h35);
    push(8'h12);
    chk("t1_cnt2", wp_count, 2);
    start  = 1'b1;
    follow = 1;
    run_seq(200);
    chk("t1_moves", n_mv, 2);
    chk("t1_tgt0",  tgt_log[0], 8'h35);
    chk("t1_tgt1",  tgt_log[1], 8'h12);
    chk("t1_gap",   low_log[0], 9);
    chk("t1_dwell", low_log[1], 8);
    chk("t1_done",  n_done, 1);
    chk("t1_err",   n_err, 0);
    chk("t1_cnt0",  wp_count, 0);
    start  = 1'b0;
    follow = 0;
    cyc();
    chk("t1_done_pulse", done, 0);

    // Overfill: fifth push dropped.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    chk("t2_cnt4", wp_count, 4);
    chk("t2_full", wp_full, 1);
    chk("t2_noerr", err, 0);
    push(8'h05);
    chk("t2_err",   err, 1);
    chk("t2_cnt",   wp_count, 4);
    chk("t2_full2", wp_full, 1);
    cyc();
    chk("t2_err_pulse", err, 0);

    // Push during LOAD into a full FIFO.
    start = 1'b1;
    cyc();
    wp_in   = 8'h06;
    wp_push = 1'b1;
    cyc();
    wp_push = 1'b0;
    start   = 1'b0;
    chk("t3_cnt",  wp_count, 4);
    chk("t3_full", wp_full, 1);
    chk("t3_err",  err, 0);
    chk("t3_tgt",  target_out, 8'h01);
    chk("t3_mot",  motion, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t3_ab_busy", busy, 0);
    chk("t3_ab_mot",  motion, 0);
    chk("t3_ab_cnt",  wp_count, 4);
    chk("t3_ab_tgt",  target_out, 8'h01);

    // Drain and confirm FIFO order.
    start  = 1'b1;
    follow = 1;
    run_seq(400);
    chk("t3_moves", n_mv, 4);
    chk("t3_o0", tgt_log[0], 8'h02);
    chk("t3_o1", tgt_log[1], 8'h03);
    chk("t3_o2", tgt_log[2], 8'h04);
    chk("t3_o3", tgt_log[3], 8'h06);
    chk("t3_done", n_done, 1);
    chk("t3_cnt0", wp_count, 0);
    start  = 1'b0;
    follow = 0;
    cyc();

    // Timeout: unreachable target.
    x_pos = 4'h0;
    y_pos = 4'h0;
    push(8'h99);
    start = 1'b1;
    run_seq(100);
    start = 1'b0;
    chk("t4_hi",   n_hi, 20);
    chk("t4_err",  n_err, 1);
    chk("t4_done", n_done, 0);
    chk("t4_err_now", err, 1);
    cyc();
    chk("t4_err_pulse", err, 0);
    chk("t4_mot", motion, 0);
    chk("t4_busy", busy, 0);
    chk("t4_cnt", wp_count, 0);

    // Abort then reset mid-MOVE.
    push(8'h21);
    push(8'h22);
    push(8'h23);
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    chk("t5_mv", motion, 1);
    chk("t5_cnt", wp_count, 2);
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_ab_busy", busy, 0);
    chk("t5_ab_mot", motion, 0);
    chk("t5_ab_cnt", wp_count, 2);
    chk("t5_ab_tgt", target_out, 8'h21);
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    chk("t5_tgt2", target_out, 8'h22);
    cyc();
    reset   = 1'b1;
    abort   = 1'b1;
    start   = 1'b1;
    wp_in   = 8'h44;
    wp_push = 1'b1;
    cyc();
    reset   = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    wp_push = 1'b0;
    chk("t5_rs_cnt",  wp_count, 0);
    chk("t5_rs_tgt",  target_out, 8'h00);
    chk("t5_rs_mot",  motion, 0);
    chk("t5_rs_busy", busy, 0);
    chk("t5_rs_full", wp_full, 0);
    cyc();
    chk("t5_rs_idle", busy, 0);

    // Non-BCD waypoint.
    push(8'hA3);
`ifdef XYSEQ_BCD_CHECK_EN
    chk("t6_cnt", wp_count, 0);
    chk("t6_err", err, 1);
`else
    chk("t6_cnt", wp_count, 1);
    chk("t6_err", err, 0);
`endif
    cyc();
    chk("t6_err_clr", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xy_waypoint_seq.md
XY_WAYPOINT_SEQ -- requirements
Module: xy_waypoint_seq

Interface
REQ-001 Parameter DEPTH, default 4: waypoint FIFO depth; power of two, 2..16.
REQ-002 Parameter DWELL, default 8: cycles held at each reached waypoint, 1..255.
REQ-003 Parameter TIMEOUT, default 255: maximum MOVE cycles before abandon, 1..65535.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wp_in  in  8  waypoint, BCD: [7:4] X target, [3:0] Y target.
REQ-007 wp_push  in  1  write wp_in into FIFO this cycle.
REQ-008 start  in  1  level; begin/continue sequencing while high.
REQ-009 abort  in  1  pulse; stop current move, return to IDLE.
REQ-010 x_pos  in  4  current X position from the XY controller.
REQ-011 y_pos  in  4  current Y position from the XY controller.
REQ-012 target_out  out  8  target presented to the XY controller ([7:4] X, [3:0] Y).
REQ-013 motion  out  1  motion request to the XY controller.
REQ-014 wp_full  out  1  FIFO holds DEPTH entries.
REQ-015 wp_count  out  5  FIFO occupancy, 0..DEPTH.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when the final queued waypoint completes dwell.
REQ-018 err  out  1  one-cycle pulse on timeout or rejected push.

Function
REQ-019 States SHALL be IDLE, LOAD, MOVE, DWELL; encoding free.
REQ-020 IDLE: start=1 and wp_count>0 -> LOAD next cycle; otherwise stay.
REQ-021 LOAD (1 cycle): target_out <= FIFO head, head popped, motion=0 -> MOVE.
REQ-022 MOVE: motion=1; timeout counter increments each cycle from 0 at entry.
REQ-023 MOVE: {x_pos,y_pos}==target_out -> DWELL next cycle, motion=0 from that cycle.
REQ-024 MOVE: counter reaches TIMEOUT without arrival -> IDLE, err pulse; remaining FIFO entries retained.
REQ-025 MOVE: start=0 SHALL NOT interrupt the move; start is sampled only in IDLE and at DWELL end.
REQ-026 DWELL: motion=0 for exactly DWELL cycles; then wp_count>0 and start=1 -> LOAD, else -> IDLE.
REQ-027 done SHALL pulse on the DWELL->IDLE transition only when wp_count==0.
REQ-028 abort in any state -> IDLE next cycle, motion=0, counters cleared, FIFO contents retained, target_out held.
REQ-029 Push with FIFO not full SHALL be accepted; push while full SHALL be dropped and pulse err.
REQ-030 Push and pop in the same cycle SHALL both take effect; wp_count unchanged; accepted even when full.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; ordering strictly first-in first-out.
REQ-032 wp_full and wp_count SHALL be registered and reflect the FIFO after the current edge.
REQ-033 Arrival compare SHALL be exact 8-bit equality; no tolerance.

Reset
REQ-034 reset=1 SHALL force IDLE, empty FIFO, wp_count=0, wp_full=0, target_out=8'h00, motion=0, busy=0, done=0, err=0.
REQ-035 reset mid-MOVE SHALL discard all queued waypoints; motion low the cycle after reset is sampled.
REQ-036 reset SHALL dominate abort, wp_push and start in the same cycle.

Configuration
REQ-037 Macro XYSEQ_BCD_CHECK_EN defined: push with either nibble >9 SHALL be rejected, not stored, and pulse err.
REQ-038 Macro XYSEQ_BCD_CHECK_EN undefined: any 8-bit value SHALL be accepted; nibble range not checked.

Verification
REQ-039 Push 8'h35, 8'h12; start=1; model follows target -> target_out 8'h35 then 8'h12, each after DWELL=8 cycles at arrival; done pulses once; wp_count 0.
REQ-040 Push 5 entries with DEPTH=4 -> 5th dropped, err pulse, wp_full=1, wp_count=4.
REQ-041 Push 8'h99, position held at 8'h00, TIMEOUT=20 -> motion high 20 cycles, then IDLE, err pulse, motion=0.
REQ-042 Full FIFO, push during LOAD -> push accepted, wp_count stays 4, order preserved.
REQ-043 abort mid-MOVE with 2 entries queued -> IDLE next cycle, wp_count=2; reset mid-MOVE -> wp_count=0, target_out=8'h00.
REQ-044 With XYSEQ_BCD_CHECK_EN, push 8'hA3 -> rejected, err pulse, wp_count unchanged; without macro -> stored.
